bus_uart_tx: RTL and testbench

- Memory-mapped UART transmitter peripheral. It is a responder on one slave port of the split-transaction crossbar (req/we/addr/be/wdata, ack/resp/rdata).
- CPU tiles write bytes into a TX FIFO; an 8N1 serializer drives tx_o at a programmable bit period.
- It is the device-side transmit counterpart to the host-facing UART debug initiator, and lets tiles emit console output.

---
 rtl/bus_uart_tx_pkg.sv | 15 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/bus_uart_tx.sv | 126 ++++++++++++
 tb/tb_bus_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_uart_tx_pkg.sv
// bus_uart_tx_pkg: shared register map, STATUS layout, serializer states and divider floor
package bus_uart_tx_pkg;
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVIDER = 2'd2;
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam logic [15:0] DIV_MIN = 16'd2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count
//   clk_i, rst_i     clock, synchronous active-high reset (flushes contents)
//   push_i, wdata_i  write strobe and data (ignored when full)
//   pop_i, rdata_o   read strobe (ignored when empty) and head-of-queue data
//   full_o, empty_o  registered status flags
//   count_o          number of stored entries
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO on a crossbar slave port
//   clk_i, rst_i   system clock, synchronous active-high reset
//   bus_req/we/addr/be/wdata   slave request (addr[3:2] selects TXDATA/STATUS/DIVIDER)
//   bus_ack        combinational accept; withheld only for a TXDATA byte push into a full FIFO
//   bus_resp/rdata read response one cycle after the accepted read, rdata zero otherwise
//   tx_o           serial output, idle high
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic        bus_resp,
    output logic [31:0] bus_rdata,
    output logic        tx_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic full, empty, push, pop, rd_en, unused_bits;
    logic [7:0] head;
    logic [CW-1:0] count;
    logic [1:0] reg_sel;
    logic [15:0] div_q, div_d, div_wr;
    tx_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d, reload_q, reload_d;
    logic tx_q, tx_d, resp_q;
    logic [31:0] rdata_q, status, rd_val;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(push), .wdata_i(bus_wdata[7:0]),
        .pop_i(pop), .rdata_o(head), .full_o(full), .empty_o(empty), .count_o(count)
    );

    assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_be[3:2], bus_wdata[31:16]};
    assign reg_sel = bus_addr[3:2];
    // Full is the registered flag, so a same-cycle pop never unblocks a stalled push.
    assign bus_ack = bus_req && !(bus_we && reg_sel == REG_TXDATA && bus_be[0] && full);
    assign push    = bus_ack && bus_we && reg_sel == REG_TXDATA && bus_be[0];
    assign rd_en   = bus_ack && !bus_we;
    assign div_wr  = {bus_be[1] ? bus_wdata[15:8] : div_q[15:8], bus_be[0] ? bus_wdata[7:0] : div_q[7:0]};
    assign div_d   = (bus_ack && bus_we && reg_sel == REG_DIVIDER) ? clamp_div(div_wr) : div_q;
    assign bus_resp  = resp_q;
    assign bus_rdata = rdata_q;
    assign tx_o      = tx_q;

    always_comb begin
        status = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = state_q != IDLE;
        status[ST_COUNT_LSB +: 6] = 6'(count);
        rd_val = (reg_sel == REG_STATUS) ? status : (reg_sel == REG_DIVIDER) ? {16'b0, div_q} : '0;
    end

    // cnt_q counts down the clocks left in the current bit; a bit ends when it reaches zero.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        if (state_q == IDLE || (state_q == STOP && cnt_q == '0)) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            if (!empty) begin
                pop      = 1'b1;
                shift_d  = head;
                reload_d = div_q;
                cnt_d    = div_q - 16'd1;
                state_d  = START;
                tx_d     = 1'b0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = reload_q - 16'd1;
            if (state_q == START) begin
                state_d = DATA;
                idx_d   = '0;
                tx_d    = shift_q[0];
            end else if (idx_q == 3'd7) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end else begin
                idx_d   = idx_q + 3'd1;
                shift_d = shift_q >> 1;
                tx_d    = shift_q[1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            reload_q <= DIV_DEFAULT;
            tx_q     <= 1'b1;
            div_q    <= DIV_DEFAULT;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tx_q     <= tx_d;
            div_q    <= div_d;
            resp_q   <= rd_en;
            rdata_q  <= rd_en ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: scoreboard bench for bus_uart_tx (bus read responses and UART frames)
module tb_bus_uart_tx;
    typedef struct {
        logic [7:0] b;
        int         d;
    } txe_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req = 1'b0, bus_we = 1'b0;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic [3:0]  bus_be = '0;
    logic        bus_ack, bus_resp, tx_o;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;
    logic abort_req = 1'b1;
    logic mon_busy = 1'b0;
    logic [31:0] exp_q[$];
    txe_t txq[$];

    bus_uart_tx dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_resp(bus_resp), .bus_rdata(bus_rdata), .tx_o(tx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, output int waited, output logic tx_prev, output logic tx_now);
        @(negedge clk_i);
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_be = be; bus_wdata = d;
        #1;
        waited = 0;
        tx_now = tx_o;
        tx_prev = tx_o;
        while (!bus_ack && waited < 20000) begin
            @(negedge clk_i);
            #1;
            waited++;
            tx_prev = tx_now;
            tx_now = tx_o;
        end
        if (!bus_ack) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: actual=no_ack required=ack addr=0x%08h", a);
        end
        @(posedge clk_i);
        #1;
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        int w; logic tp, tn;
        bus_xfer(1'b1, a, be, d, w, tp, tn);
        check32("wr_ack_wait", 32'(w), 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        int w; logic tp, tn;
        exp_q.push_back(exp);
        bus_xfer(1'b0, a, 4'hF, 32'h0, w, tp, tn);
        check32("rd_ack_wait", 32'(w), 32'd0);
    endtask

    task automatic wait_tx_done(input int lim);
        int i;
        for (i = 0; i < lim && (txq.size() != 0 || mon_busy); i++) @(negedge clk_i);
        check32("tx_done_in_time", 32'(i < lim), 32'd1);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic do_reset();
        abort_req = 1'b1;
        txq.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        abort_req = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus_resp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: actual=0x%08h required=no_response", bus_rdata);
                end else begin
                    check32("rdata", bus_rdata, exp_q.pop_front());
                end
            end else begin
                check32("rdata_idle", bus_rdata, 32'h0);
            end
        end
    end

    initial begin : uart_mon
        txe_t e;
        logic [9:0] pat, ga, gb;
        forever begin
            @(negedge clk_i);
            if (!abort_req && !rst_i && tx_o === 1'b0) begin
                if (txq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: actual=start_bit required=idle_high");
                    while (tx_o === 1'b0 && !abort_req) @(negedge clk_i);
                end else begin
                    e = txq.pop_front();
                    mon_busy = 1'b1;
                    pat = {1'b1, e.b, 1'b0};
                    ga = '0;
                    gb = '0;
                    for (int k = 0; k < 10 * e.d && !abort_req; k++) begin
                        if (k > 0) @(negedge clk_i);
                        if (k % e.d == 0) ga[k / e.d] = tx_o;
                        if (k % e.d == e.d - 1) gb[k / e.d] = tx_o;
                    end
                    if (!abort_req) begin
                        check32("frame_bit_first_clk", 32'(ga), 32'(pat));
                        check32("frame_bit_last_clk", 32'(gb), 32'(pat));
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : main
        int w, lows;
        logic tp, tn;
        repeat (3) @(negedge clk_i);
        check32("reset_tx", 32'(tx_o), 32'd1);
        check32("reset_ack", 32'(bus_ack), 32'd0);
        check32("reset_resp", 32'(bus_resp), 32'd0);
        check32("reset_rdata", bus_rdata, 32'h0);
        rst_i = 1'b0;
        abort_req = 1'b0;

        rd(32'h4, 32'h0000_0002);
        rd(32'h8, 32'h0000_0010);
        rd(32'h0, 32'h0);
        rd(32'hC, 32'h0);

        wr(32'h8, 4'b0011, 32'd4);
        txq.push_back('{8'h55, 4});
        wr(32'h0, 4'b0001, 32'h55);
        repeat (8) @(negedge clk_i);
        rd(32'h4, 32'h0000_0006);
        wait_tx_done(200);

        wr(32'h8, 4'b0011, 32'd1);
        rd(32'h8, 32'h0000_0002);
        wr(32'h8, 4'b0010, 32'h0000_AB00);
        rd(32'h8, 32'h0000_AB02);
        wr(32'hC, 4'b1111, 32'hFFFF_FFFF);
        rd(32'hC, 32'h0);
        rd(32'h8, 32'h0000_AB02);
        wr(32'h0, 4'b1110, 32'h0000_00FF);
        rd(32'h4, 32'h0000_0002);
        lows = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1) lows++;
        end
        check32("be0_clear_no_tx", 32'(lows), 32'd0);

        wr(32'h8, 4'b0011, 32'd4);
        txq.push_back('{8'hA5, 4});
        txq.push_back('{8'h3C, 8});
        wr(32'h0, 4'b0001, 32'hA5);
        wr(32'h0, 4'b0001, 32'h3C);
        repeat (5) @(negedge clk_i);
        wr(32'h8, 4'b0011, 32'd8);
        rd(32'h8, 32'h0000_0008);
        wait_tx_done(300);

        wr(32'h8, 4'b0011, 32'd1000);
        for (int i = 0; i < 9; i++) begin
            txq.push_back('{8'(8'h30 + i), 1000});
            wr(32'h0, 4'b0001, 32'(8'h30 + i));
        end
        rd(32'h4, 32'h0000_0805);
        bus_xfer(1'b1, 32'h0, 4'b0001, 32'h39, w, tp, tn);
        check32("full_push_stalled", 32'(w > 0), 32'd1);
        check32("ack_after_second_pop", {30'b0, tp, tn}, 32'h2);
        do_reset();
        rd(32'h4, 32'h0000_0002);

        wr(32'h8, 4'b0011, 32'd4);
        txq.push_back('{8'h00, 4});
        wr(32'h0, 4'b0001, 32'h00);
        wr(32'h0, 4'b0001, 32'h22);
        wr(32'h0, 4'b0001, 32'h33);
        wr(32'h0, 4'b0001, 32'h44);
        repeat (4) @(negedge clk_i);
        check32("tx_low_in_data", 32'(tx_o), 32'd0);
        abort_req = 1'b1;
        txq.delete();
        rst_i = 1'b1;
        @(negedge clk_i);
        check32("rst_mid_frame_tx", 32'(tx_o), 32'd1);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        abort_req = 1'b0;
        rd(32'h4, 32'h0000_0002);
        lows = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1) lows++;
        end
        check32("no_frames_after_rst", 32'(lows), 32'd0);

        repeat (3) @(negedge clk_i);
        check32("resp_leftover", 32'(exp_q.size()), 32'd0);
        check32("tx_leftover", 32'(txq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
